// File: rtl/pool_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pool_arb
//
// Round-robin arbiter that shares one synchronous-read single-port memory
// pool (32-bit words, 4 byte lanes) between NREQ requesters. Each access is
// sequenced IDLE -> ACC -> RD -> RSP, so the pool completes one access
// every 4 cycles. A requester can lock the pool so that only it is granted
// until it drops its lock line.
//
// Ports
//   clk       clock
//   rst       asynchronous reset, active low
//   req       per-requester access request
//   lock      per-requester pool-ownership request
//   op        per-requester opcode (3 bits each): 1=R1 2=R2 3=R4 5=W1 6=W2
//             7=W4; 0 and 4 are illegal
//   ai        per-requester address (ASZ bits each)
//   vi        per-requester write data (DSZ bits each)
//   gnt       one-hot current owner, held from ACC through RSP
//   ack       one-cycle completion pulse to the owner (in RSP)
//   err       1 = the completed access had an illegal opcode (valid with ack)
//   vo        lane-masked read data (valid with ack, held until next RSP)
//   busy      arbiter is not idle
//   mem_we    RAM write enable (ACC only)
//   mem_bmsk  RAM byte-lane mask (ACC only)
//   mem_a     RAM address (ACC only, otherwise 0)
//   mem_vi    RAM write data (ACC only, otherwise 0)
//   mem_vo    RAM read data, valid the cycle after the address cycle
// ---------------------------------------------------------------------------
module pool_arb #(
    parameter int NREQ = 3,
    parameter int DSZ  = 32,
    parameter int ASZ  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [3*NREQ-1:0]     op,
    input  logic [ASZ*NREQ-1:0]   ai,
    input  logic [DSZ*NREQ-1:0]   vi,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  err,
    output logic [DSZ-1:0]        vo,
    output logic                  busy,
    output logic                  mem_we,
    output logic [3:0]            mem_bmsk,
    output logic [ASZ-1:0]        mem_a,
    output logic [DSZ-1:0]        mem_vi,
    input  logic [DSZ-1:0]        mem_vo
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACC    = 2'd1;
    localparam logic [1:0] S_RD     = 2'd2;
    localparam logic [1:0] S_RSP    = 2'd3;
    localparam logic [1:0] LAST_IDX = 2'(NREQ - 1);

    logic [1:0]      r_state;
    logic [1:0]      r_ptr;
    logic            r_lockAct;
    logic [1:0]      r_owner;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_ack;
    logic            r_err;
    logic [DSZ-1:0]  r_vo;
    logic [2:0]      r_op;
    logic [ASZ-1:0]  r_a;
    logic [DSZ-1:0]  r_wd;

    logic [NREQ-1:0] w_ownerOh;
    logic            w_locked;
    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [1:0]      w_win;
    logic [NREQ-1:0] w_winOh;
    logic [2:0]      w_dist;
    logic [2:0]      w_bestD;
    logic [2:0]      w_selOp;
    logic [ASZ-1:0]  w_selA;
    logic [DSZ-1:0]  w_selVi;
    logic            w_selLock;
    logic [1:0]      w_nextPtr;
    logic            w_inAcc;
    logic            w_isWrite;
    logic [3:0]      w_laneMask;
    logic [DSZ-1:0]  w_rdData;

    // The lock only stays in force while the owner keeps its lock line high;
    // the moment it drops, this same IDLE edge arbitrates as if unlocked.
    always_comb begin
        w_ownerOh = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (r_owner == 2'(j)) w_ownerOh[j] = 1'b1;
        end
        w_locked = r_lockAct & (|(lock & w_ownerOh));
        w_elig   = w_locked ? (req & w_ownerOh) : req;
    end

    // Round-robin pick: the eligible requester closest to the pointer in the
    // order ptr, ptr+1, ... wins. Distances are distinct, so the smallest one
    // is unique. The winner's inputs are muxed out here for capture.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_winOh   = '0;
        w_dist    = '0;
        w_bestD   = '0;
        w_selOp   = '0;
        w_selA    = '0;
        w_selVi   = '0;
        w_selLock = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (3'(j) >= {1'b0, r_ptr}) w_dist = 3'(j) - {1'b0, r_ptr};
            else                        w_dist = 3'(j) + 3'(NREQ) - {1'b0, r_ptr};
            if (w_elig[j] && (!w_found || (w_dist < w_bestD))) begin
                w_found    = 1'b1;
                w_bestD    = w_dist;
                w_win      = 2'(j);
                w_winOh    = '0;
                w_winOh[j] = 1'b1;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (w_winOh[j]) begin
                w_selOp   = op[3*j +: 3];
                w_selA    = ai[ASZ*j +: ASZ];
                w_selVi   = vi[DSZ*j +: DSZ];
                w_selLock = lock[j];
            end
        end
        w_nextPtr = (w_win == LAST_IDX) ? 2'd0 : (w_win + 2'd1);
    end

    // Opcode decode: the low two bits give the access size, bit 2 selects a
    // write. A size field of 0 marks the two illegal codes (0 and 4).
    always_comb begin
        case (r_op[1:0])
            2'd1:    w_laneMask = 4'b0001;
            2'd2:    w_laneMask = 4'b0011;
            2'd3:    w_laneMask = 4'b1111;
            default: w_laneMask = 4'b0000;
        endcase
        w_isWrite = r_op[2] & (r_op[1:0] != 2'd0);
        w_inAcc   = (r_state == S_ACC);
    end

    // Read data with unused lanes cleared; writes and illegal codes return 0.
    always_comb begin
        w_rdData = '0;
        if (!r_op[2]) begin
            case (r_op[1:0])
                2'd1:    w_rdData[7:0]  = mem_vo[7:0];
                2'd2:    w_rdData[15:0] = mem_vo[15:0];
                2'd3:    w_rdData       = mem_vo;
                default: w_rdData       = '0;
            endcase
        end
    end

    // Main sequencer. Arbitration and input capture happen only on the IDLE
    // edge; the rest of the access runs unconditionally. ack/vo/err update
    // together at the RD edge so they line up with the RSP cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_lockAct <= 1'b0;
            r_owner   <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_vo      <= '0;
            r_op      <= '0;
            r_a       <= '0;
            r_wd      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_locked) r_lockAct <= 1'b0;
                    if (w_found) begin
                        r_state   <= S_ACC;
                        r_gnt     <= w_winOh;
                        r_ptr     <= w_nextPtr;
                        r_owner   <= w_win;
                        r_lockAct <= w_selLock;
                        r_op      <= w_selOp;
                        r_a       <= w_selA;
                        r_wd      <= w_selVi;
                    end
                end
                S_ACC: begin
                    r_state <= S_RD;
                end
                S_RD: begin
                    r_state <= S_RSP;
                    r_ack   <= r_gnt;
                    r_err   <= (r_op[1:0] == 2'd0);
                    r_vo    <= w_rdData;
                end
                S_RSP: begin
                    r_state <= S_IDLE;
                    r_ack   <= '0;
                    r_gnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The memory port is only driven during ACC so that a reset or any other
    // state leaves the RAM untouched.
    assign mem_we   = w_inAcc & w_isWrite;
    assign mem_bmsk = w_inAcc ? w_laneMask : 4'b0000;
    assign mem_a    = w_inAcc ? r_a : '0;
    assign mem_vi   = w_inAcc ? r_wd : '0;

    assign gnt  = r_gnt;
    assign ack  = r_ack;
    assign err  = r_err;
    assign vo   = r_vo;
    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_pool_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pool_arb
//
// Testbench for pool_arb with three requesters. A small behavioural RAM
// (256 words, byte-lane writes, one-cycle read latency) sits on the memory
// port. Directed vectors, hand-written multi-cycle sequences and a random
// transaction loop with a transaction-level reference model exercise the
// arbiter.
// ---------------------------------------------------------------------------
module tb_pool_arb;

    localparam int NREQ = 3;
    localparam int DSZ  = 32;
    localparam int ASZ  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ-1:0]     lock;
    logic [3*NREQ-1:0]   op;
    logic [ASZ*NREQ-1:0] ai;
    logic [DSZ*NREQ-1:0] vi;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic                err;
    logic [DSZ-1:0]      vo;
    logic                busy;
    logic                mem_we;
    logic [3:0]          mem_bmsk;
    logic [ASZ-1:0]      mem_a;
    logic [DSZ-1:0]      mem_vi;
    logic [DSZ-1:0]      mem_vo;

    logic                loadRam;
    logic [31:0]         ram [0:255];
    logic [31:0]         modelMem [0:255];

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        int          port;
        logic [2:0]  opc;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        expWe;
        logic [3:0]  expBmsk;
        logic [31:0] expVo;
        logic        expErr;
    } vec_t;

    vec_t vecs [10];

    int          mPtr;
    int          mOwner;
    int          win;
    logic [2:0]  mOp;
    logic [15:0] mAddr;
    logic [31:0] mData;
    logic [31:0] mWord;
    logic [31:0] expVo;
    logic        expErr;
    logic        expWe;
    logic [3:0]  expBmsk;
    logic [2:0]  rrWho [6];
    int          rrCyc [6];
    int          nAck;

    pool_arb #(.NREQ(NREQ), .DSZ(DSZ), .ASZ(ASZ)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .op       (op),
        .ai       (ai),
        .vi       (vi),
        .gnt      (gnt),
        .ack      (ack),
        .err      (err),
        .vo       (vo),
        .busy     (busy),
        .mem_we   (mem_we),
        .mem_bmsk (mem_bmsk),
        .mem_a    (mem_a),
        .mem_vi   (mem_vi),
        .mem_vo   (mem_vo)
    );

    always #5 clk = ~clk;

    // Initial RAM image: a few fixed words for the directed vectors, a
    // scrambled pattern everywhere else.
    function automatic logic [31:0] initWord(input int i);
        case (i)
            16:      return 32'h11223344;
            32:      return 32'h55667788;
            36:      return 32'hDEADBEEF;
            default: return 32'(i + 1) * 32'h9E3779B9;
        endcase
    endfunction

    // Behavioural single-port RAM: byte-lane writes, registered read.
    always @(posedge clk) begin
        if (loadRam) begin
            for (int i = 0; i < 256; i++) ram[i] <= initWord(i);
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_bmsk[b]) ram[mem_a[7:0]][8*b +: 8] <= mem_vi[8*b +: 8];
            end
        end
        mem_vo <= ram[mem_a[7:0]];
    end

    // Safety net in case the DUT stalls the sequence forever.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got time limit reached, expected normal completion");
        $fatal(1, "[TB] simulation time limit");
    end

    // Advance one clock and settle just after the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic setPort(input int p, input logic r, input logic l, input logic [2:0] o,
                           input logic [15:0] a, input logic [31:0] d);
        req[p]          = r;
        lock[p]         = l;
        op[3*p +: 3]    = o;
        ai[16*p +: 16]  = a;
        vi[32*p +: 32]  = d;
    endtask

    // Drive one directed vector: only the selected port requests.
    task automatic applyStimulus(input vec_t v);
        req  = '0;
        lock = '0;
        setPort(v.port, 1'b1, 1'b0, v.opc, v.addr, v.wdata);
    endtask

    function automatic logic [3:0] specMask(input logic [2:0] o);
        case (o)
            3'd1, 3'd5: return 4'b0001;
            3'd2, 3'd6: return 4'b0011;
            3'd3, 3'd7: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    initial begin
        vecs[0] = '{0, 3'd3, 16'h0010, 32'h01010101, 1'b0, 4'b1111, 32'h11223344, 1'b0};
        vecs[1] = '{1, 3'd6, 16'h0020, 32'hAABBCCDD, 1'b1, 4'b0011, 32'h00000000, 1'b0};
        vecs[2] = '{1, 3'd1, 16'h0020, 32'h02020202, 1'b0, 4'b0001, 32'h000000DD, 1'b0};
        vecs[3] = '{0, 3'd4, 16'h0020, 32'h03030303, 1'b0, 4'b0000, 32'h00000000, 1'b1};
        vecs[4] = '{2, 3'd2, 16'h0020, 32'h04040404, 1'b0, 4'b0011, 32'h0000CCDD, 1'b0};
        vecs[5] = '{2, 3'd5, 16'h0024, 32'h11223344, 1'b1, 4'b0001, 32'h00000000, 1'b0};
        vecs[6] = '{0, 3'd3, 16'h0024, 32'h05050505, 1'b0, 4'b1111, 32'hDEADBE44, 1'b0};
        vecs[7] = '{1, 3'd0, 16'h0010, 32'h06060606, 1'b0, 4'b0000, 32'h00000000, 1'b1};
        vecs[8] = '{0, 3'd2, 16'h0010, 32'h07070707, 1'b0, 4'b0011, 32'h00003344, 1'b0};
        vecs[9] = '{1, 3'd3, 16'h0020, 32'h08080808, 1'b0, 4'b1111, 32'h5566CCDD, 1'b0};

        req = '0; lock = '0; op = '0; ai = '0; vi = '0;
        rst = 1'b0;
        loadRam = 1'b1;
        for (int i = 0; i < 256; i++) modelMem[i] = initWord(i);
        tick;
        tick;
        loadRam = 1'b0;
        checkOutput("resetCtl", {gnt, ack, err, busy, mem_we, mem_bmsk}, '0);
        checkOutput("resetData", {vo, mem_a}, '0);
        #2 rst = 1'b1;

        // Three ports requesting R4 continuously: strict rotation, 4 cycles apart.
        for (int p = 0; p < NREQ; p++) setPort(p, 1'b1, 1'b0, 3'd3, 16'(64 + p), 32'h0);
        nAck = 0;
        for (int c = 1; c <= 30 && nAck < 6; c++) begin
            tick;
            if (ack != '0) begin
                rrWho[nAck] = ack;
                rrCyc[nAck] = c;
                checkOutput("rrData", vo, modelMem[64 + (nAck % 3)]);
                nAck++;
                if (nAck == 6) req = '0;
            end
        end
        checkOutput("rrAckCount", nAck, 6);
        for (int k = 0; k < nAck; k++) begin
            checkOutput("rrOrder", rrWho[k], 3'b001 << (k % 3));
            if (k == 0) checkOutput("rrFirstLatency", rrCyc[k], 3);
            else        checkOutput("rrSpacing", rrCyc[k] - rrCyc[k-1], 4);
        end
        tick;

        // Directed single-requester vectors.
        for (int n = 0; n < 10; n++) begin
            applyStimulus(vecs[n]);
            tick;
            checkOutput("vecGnt", {busy, gnt}, {1'b1, 3'b001 << vecs[n].port});
            checkOutput("vecMemAcc", {mem_we, mem_bmsk, mem_a},
                        {vecs[n].expWe, vecs[n].expBmsk, vecs[n].addr});
            if (vecs[n].expWe) checkOutput("vecMemWdata", mem_vi, vecs[n].wdata);
            req = '0;
            tick;
            checkOutput("vecMemRd", {busy, mem_we, mem_bmsk, mem_a, mem_vi}, {1'b1, 53'h0});
            tick;
            checkOutput("vecAck", {busy, ack, err}, {1'b1, 3'b001 << vecs[n].port, vecs[n].expErr});
            checkOutput("vecVo", vo, vecs[n].expVo);
            tick;
            checkOutput("vecIdleHold", {busy, gnt, ack, vo}, {1'b0, 6'b0, vecs[n].expVo});
        end

        // Reset in the middle of a W4 access, then a pending request from port 1.
        setPort(0, 1'b1, 1'b0, 3'd7, 16'h0030, 32'hCAFEF00D);
        tick;
        checkOutput("abortWeBefore", {mem_we, mem_bmsk}, {1'b1, 4'b1111});
        req = '0;
        setPort(1, 1'b1, 1'b0, 3'd3, 16'h0040, 32'h0);
        #2 rst = 1'b0;
        #1;
        checkOutput("abortCtl", {gnt, ack, err, busy, mem_we, mem_bmsk}, '0);
        checkOutput("abortData", {vo, mem_a}, '0);
        checkOutput("abortWdata", mem_vi, '0);
        @(negedge clk);
        rst = 1'b1;
        tick;
        checkOutput("postResetGnt", gnt, 3'b010);
        req = '0;
        tick;
        tick;
        checkOutput("postResetAck", {ack, err}, {3'b010, 1'b0});
        checkOutput("postResetVo", vo, modelMem[64]);
        tick;

        // Port 2 locks the pool for three reads while ports 0 and 1 wait.
        setPort(2, 1'b1, 1'b1, 3'd3, 16'h0044, 32'h0);
        for (int t = 0; t < 3; t++) begin
            tick;
            checkOutput("lockGnt", gnt, 3'b100);
            if (t == 0) begin
                setPort(0, 1'b1, 1'b0, 3'd3, 16'h0041, 32'h0);
                setPort(1, 1'b1, 1'b0, 3'd3, 16'h0042, 32'h0);
            end
            tick;
            tick;
            checkOutput("lockAck", ack, 3'b100);
            if (t == 2) begin
                req[2]  = 1'b0;
                lock[2] = 1'b1;
            end
            tick;
        end
        for (int t = 0; t < 2; t++) begin
            tick;
            checkOutput("lockHoldIdle", {gnt, busy}, 4'b0);
        end
        lock[2] = 1'b0;
        tick;
        checkOutput("unlockGnt", gnt, 3'b001);
        req = '0;
        tick;
        tick;
        checkOutput("unlockAck", ack, 3'b001);
        tick;

        // Random transactions against a transaction-level model.
        rst = 1'b0;
        #2 rst = 1'b1;
        mPtr   = 0;
        mOwner = -1;
        for (int n = 0; n < 150; n++) begin
            for (int p = 0; p < NREQ; p++) begin
                setPort(p, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                        3'($urandom_range(0, 7)), 16'(64 + $urandom_range(0, 191)), $urandom);
            end
            if (mOwner >= 0 && !lock[mOwner]) mOwner = -1;
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mPtr + k) % NREQ;
                if (win < 0 && req[idx] && (mOwner < 0 || mOwner == idx)) win = idx;
            end
            if (win < 0) begin
                tick;
                checkOutput("rndIdle", {gnt, busy}, 4'b0);
            end else begin
                mPtr   = (win + 1) % NREQ;
                mOwner = lock[win] ? win : -1;
                mOp    = op[3*win +: 3];
                mAddr  = ai[16*win +: 16];
                mData  = vi[32*win +: 32];
                mWord  = modelMem[mAddr[7:0]];
                expBmsk = specMask(mOp);
                expWe   = (mOp >= 3'd5);
                expErr  = (mOp == 3'd0) || (mOp == 3'd4);
                expVo   = 32'h0;
                case (mOp)
                    3'd1: expVo = {24'h0, mWord[7:0]};
                    3'd2: expVo = {16'h0, mWord[15:0]};
                    3'd3: expVo = mWord;
                    3'd5: modelMem[mAddr[7:0]][7:0]  = mData[7:0];
                    3'd6: modelMem[mAddr[7:0]][15:0] = mData[15:0];
                    3'd7: modelMem[mAddr[7:0]]       = mData;
                    default: expVo = 32'h0;
                endcase
                tick;
                checkOutput("rndGnt", {busy, gnt}, {1'b1, 3'b001 << win});
                checkOutput("rndMem", {mem_we, mem_bmsk, mem_a}, {expWe, expBmsk, mAddr});
                tick;
                tick;
                checkOutput("rndAck", {ack, err}, {3'b001 << win, expErr});
                checkOutput("rndVo", vo, expVo);
                tick;
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
